mb2cpx_assembler: RTL

Return-path block of the CCX-to-MicroBlaze bridge. It drains CPX return packets from the MicroBlaze FSL master FIFO as 32-bit words, reassembles each into a full-width CPX packet, and drives the result onto the SPARC CPX input as a one-cycle ready pulse. Atomic pairs are released only once both halves are assembled, and then in back-to-back cycles, as the core requires.

---
 rtl/mb2cpx_assembler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mb2cpx_assembler.sv
// Reassembles CPX return packets from 32-bit FSL words (1 header + 4 body words)
// and presents each on the SPARC CPX input as a one-cycle ready pulse; atomic pairs go out back-to-back.
module mb2cpx_assembler #(
  parameter int CPX_WIDTH = 145
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic [31:0]          fsl_s_data,
  input  logic                 fsl_s_control,
  input  logic                 fsl_s_exists,
  output logic                 fsl_s_read,
  output logic [CPX_WIDTH-1:0] cpx_spc_data_cx2,
  output logic                 cpx_spc_data_rdy_cx2,
  output logic                 err_hdr,
  output logic                 err_frame
);

  localparam int HW = CPX_WIDTH - 128;

  typedef enum logic [1:0] {HDR, BODY, EMIT0, EMIT1} state_t;

  state_t               state_reg;
  logic                 slot_reg;
  logic [1:0]           cnt_reg;
  logic                 atom_reg;
  logic [CPX_WIDTH-1:0] pkt0_reg;
  logic [CPX_WIDTH-1:0] pkt1_reg;

  logic [CPX_WIDTH-1:0] fill_pkt;
  logic [CPX_WIDTH-1:0] fill_hdr;
  logic [CPX_WIDTH-1:0] fill_body;

  assign fsl_s_read = fsl_s_exists && (state_reg == HDR || state_reg == BODY);

  // Candidate contents of the slot being filled, for both a header and a body word.
  always_comb begin
    fill_pkt  = slot_reg ? pkt1_reg : pkt0_reg;
    fill_hdr  = {fsl_s_data[HW-1:0], fill_pkt[127:0]};
    fill_body = fill_pkt;
    case (cnt_reg)
      2'd0:    fill_body[127:96] = fsl_s_data;
      2'd1:    fill_body[95:64]  = fsl_s_data;
      2'd2:    fill_body[63:32]  = fsl_s_data;
      default: fill_body[31:0]   = fsl_s_data;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_reg            <= HDR;
      slot_reg             <= 1'b0;
      cnt_reg              <= 2'd0;
      atom_reg             <= 1'b0;
      pkt0_reg             <= '0;
      pkt1_reg             <= '0;
      cpx_spc_data_cx2     <= '0;
      cpx_spc_data_rdy_cx2 <= 1'b0;
      err_hdr              <= 1'b0;
      err_frame            <= 1'b0;
    end else begin
      case (state_reg)
        HDR: begin
          if (fsl_s_exists) begin
            if (fsl_s_control) begin
              if (slot_reg) pkt1_reg <= fill_hdr;
              else          pkt0_reg <= fill_hdr;
              if (!slot_reg) atom_reg <= fsl_s_data[31];
              cnt_reg   <= 2'd0;
              state_reg <= BODY;
            end else begin
              err_hdr <= 1'b1;
            end
          end
        end
        BODY: begin
          if (fsl_s_exists) begin
            if (fsl_s_control) begin
              // Header arriving mid-packet restarts the current slot from this header.
              if (slot_reg) pkt1_reg <= fill_hdr;
              else          pkt0_reg <= fill_hdr;
              if (!slot_reg) atom_reg <= fsl_s_data[31];
              cnt_reg   <= 2'd0;
              err_frame <= 1'b1;
            end else begin
              if (slot_reg) pkt1_reg <= fill_body;
              else          pkt0_reg <= fill_body;
              cnt_reg <= cnt_reg + 2'd1;
              if (cnt_reg == 2'd3) begin
                if (!slot_reg && atom_reg) begin
                  slot_reg  <= 1'b1;
                  state_reg <= HDR;
                end else begin
                  // Output is registered, so launch pkt0 now to have it valid during EMIT0.
                  state_reg            <= EMIT0;
                  cpx_spc_data_cx2     <= slot_reg ? pkt0_reg : fill_body;
                  cpx_spc_data_rdy_cx2 <= 1'b1;
                end
              end
            end
          end
        end
        EMIT0: begin
          if (atom_reg) begin
            state_reg            <= EMIT1;
            cpx_spc_data_cx2     <= pkt1_reg;
            cpx_spc_data_rdy_cx2 <= 1'b1;
          end else begin
            state_reg            <= HDR;
            slot_reg             <= 1'b0;
            cpx_spc_data_cx2     <= '0;
            cpx_spc_data_rdy_cx2 <= 1'b0;
          end
        end
        default: begin
          state_reg            <= HDR;
          slot_reg             <= 1'b0;
          atom_reg             <= 1'b0;
          cpx_spc_data_cx2     <= '0;
          cpx_spc_data_rdy_cx2 <= 1'b0;
        end
      endcase
    end
  end

endmodule
